instr_encode_loader: RTL and testbench
======================================

// Module: instr_encode_loader
// PURPOSE
//  Packs instruction fields (IDEN, OPCODE, ADDRESS) into 16-bit instruction words.
//  Writes them into program memory at consecutive addresses through a write/ack port.
//  Acts as the writer/encoder side of the instruction decode format.
//  Sits between the program source (testbench or host loader) and program memory.
// PARAMETERS
//  MEM_DEPTH   256   number of writable words; the block writes at most this many
//  START_ADDR  8'h00 first memory address written after reset or CLEAR
// PORTS
//  CLK          in   1   single clock, all logic on rising edge
//  RST_N        in   1   synchronous, active-low reset
//  CLEAR        in   1   restart the load: pointer to START_ADDR, count to 0
//  IN_VALID     in   1   field triple on IN_* is valid
//  IN_READY     out  1   block accepts the field triple this cycle
//  IN_IDEN      in   2   instruction/memory identifier -> word[13:12]
//  IN_OPCODE    in   4   opcode -> word[11:8]
//  IN_ADDRESS   in   8   operand address -> word[7:0]
//  IN_LAST      in   1   marks the final instruction of the program
//  MEM_WE       out  1   memory write strobe
//  MEM_ADDR     out  8   memory write address
//  MEM_WDATA    out  16  encoded word; bits [15:14] are always 2'b00
//  MEM_ACK      in   1   memory accepted the write; sampled on edges where MEM_WE=1
//  DONE         out  1   load finished, held until CLEAR or reset
//  FULL         out  1   MEM_DEPTH words written, held until CLEAR or reset
//  WORD_COUNT   out  9   words written since the last reset or CLEAR
// BEHAVIOUR
//  Reset (RST_N=0 at an edge):
//   - state=IDLE; pointer=START_ADDR; WORD_COUNT=0.
//   - MEM_WE=0, MEM_ADDR=START_ADDR, MEM_WDATA=0, DONE=0, FULL=0.
//   - IN_READY=1 in the first cycle after reset is released.
//   - Reset aborts any write in progress; no partial state survives.
//  FSM states:
//   - IDLE: IN_READY=1. On IN_VALID&IN_READY, register
//     {2'b00,IN_IDEN,IN_OPCODE,IN_ADDRESS} into MEM_WDATA and IN_LAST into last_q.
//     Set MEM_WE=1 and MEM_ADDR=pointer, then go to WRITE.
//     Write latency is 1 cycle from handshake to MEM_WE.
//   - WRITE: IN_READY=0; MEM_WE, MEM_ADDR and MEM_WDATA are held stable until MEM_ACK.
//     On an edge with MEM_ACK=1: MEM_WE=0, pointer+1, WORD_COUNT+1.
//     Next state is DONE if last_q, or if WORD_COUNT+1==MEM_DEPTH (also FULL=1).
//     Otherwise next state is IDLE.
//     A MEM_ACK tied high gives 1 word per 2 cycles.
//   - DONE: IN_READY=0, DONE=1; all IN_VALID is ignored; only CLEAR or reset leaves.
//  CLEAR:
//   - In IDLE or DONE: next state IDLE, pointer=START_ADDR, WORD_COUNT=0, DONE=0, FULL=0.
//   - In WRITE: CLEAR is ignored. The in-flight write completes normally.
//  Boundaries:
//   - The pointer never wraps. FULL and DONE assert together on write number MEM_DEPTH.
//   - If IN_LAST falls on write number MEM_DEPTH, DONE=1 and FULL=1.
//   - IN_VALID while IN_READY=0 is not consumed; the source must hold its data.
//   - Memory address width is 8 bits, so MEM_DEPTH must be <=256.
//     Pointer arithmetic is modulo-free: the FSM stops before overflow.
// TESTING
//  1. Single word: IDEN=2'b01, OPCODE=4'hA, ADDRESS=8'h3C, LAST=1, MEM_ACK=1.
//     Expect MEM_WE=1 one cycle after the handshake, MEM_ADDR=8'h00, MEM_WDATA=16'h1A3C.
//     Expect DONE=1 the next cycle and WORD_COUNT=1.
//  2. Burst of 4 words with MEM_ACK=1, last word has LAST=1.
//     Expect addresses 00,01,02,03, one write every 2 cycles, DONE after the 4th, WORD_COUNT=4.
//  3. Stalled memory: MEM_ACK=0 for 3 cycles, then 1.
//     Expect MEM_WE/ADDR/WDATA stable all 4 cycles, IN_READY=0, exactly one count increment.
//  4. Full: MEM_DEPTH=4, feed 6 words with no LAST.
//     Expect 4 writes, FULL=1, DONE=1, words 5 and 6 not accepted (IN_READY=0).
//  5. Reset mid-WRITE: RST_N=0 while MEM_WE=1.
//     Expect MEM_WE=0, WORD_COUNT=0, MEM_ADDR=START_ADDR on the next cycle, IN_READY=1 after release.
//  6. CLEAR from DONE, then load IDEN=2'b11, OPCODE=4'hF, ADDRESS=8'hFF.
//     Expect MEM_ADDR=8'h00, MEM_WDATA=16'h3FFF, DONE/FULL cleared.
//     Also, CLEAR asserted during WRITE is ignored.

Source files
------------

// File: rtl/instr_encode_loader.sv
// Instruction encoder/loader: packs {iden, opcode, address} into 16-bit words
// and writes them to consecutive program-memory addresses through a write/ack port.
module instr_encode_loader #(
  parameter int unsigned MEM_DEPTH  = 256,   // must be <= 256 (8-bit address)
  parameter logic [7:0]  START_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_iden,
  input  logic [3:0]  in_opcode,
  input  logic [7:0]  in_address,
  input  logic        in_last,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        done,
  output logic        full,
  output logic [8:0]  word_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_DONE
  } state_t;

  localparam logic [8:0] DEPTH_W = 9'(MEM_DEPTH);

  state_t     state;
  logic [7:0] ptr;
  logic       last_q;
  logic [8:0] count_next;

  assign count_next = word_count + 9'd1;

  // NOTE: all state and outputs update with non-blocking assignments in one
  // clocked process, so every output is a flop and reads see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= START_ADDR;
      last_q     <= 1'b0;
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= START_ADDR;
      mem_wdata  <= '0;
      done       <= 1'b0;
      full       <= 1'b0;
      word_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // A restart takes priority over a new field triple in the same cycle.
          if (clear) begin
            ptr        <= START_ADDR;
            mem_addr   <= START_ADDR;
            word_count <= '0;
            done       <= 1'b0;
            full       <= 1'b0;
            in_ready   <= 1'b1;
          end else if (in_valid && in_ready) begin
            mem_wdata <= {2'b00, in_iden, in_opcode, in_address};
            last_q    <= in_last;
            mem_we    <= 1'b1;
            mem_addr  <= ptr;
            in_ready  <= 1'b0;
            state     <= ST_WRITE;
          end
        end

        ST_WRITE: begin
          // clear is deliberately ignored here so the in-flight write completes.
          if (mem_ack) begin
            mem_we     <= 1'b0;
            word_count <= count_next;
            if (count_next == DEPTH_W) begin
              // Pointer is held rather than incremented so it can never wrap.
              full  <= 1'b1;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              ptr <= ptr + 8'd1;
              if (last_q) begin
                done  <= 1'b1;
                state <= ST_DONE;
              end else begin
                in_ready <= 1'b1;
                state    <= ST_IDLE;
              end
            end
          end
        end

        ST_DONE: begin
          if (clear) begin
            ptr        <= START_ADDR;
            mem_addr   <= START_ADDR;
            word_count <= '0;
            done       <= 1'b0;
            full       <= 1'b0;
            in_ready   <= 1'b1;
            state      <= ST_IDLE;
          end
        end

        default: begin
          in_ready <= 1'b1;
          mem_we   <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a default-depth instance plus a
// MEM_DEPTH=4 instance sharing the same stimulus for the full-memory case.
module tb_instr_encode_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [1:0]  in_iden;
  logic [3:0]  in_opcode;
  logic [7:0]  in_address;
  logic        in_last;
  logic        mem_ack;

  logic        in_ready, mem_we, done, full;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [8:0]  word_count;

  logic        d4_in_ready, d4_mem_we, d4_done, d4_full;
  logic [7:0]  d4_mem_addr;
  logic [15:0] d4_mem_wdata;
  logic [8:0]  d4_word_count;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  instr_encode_loader dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_iden(in_iden), .in_opcode(in_opcode), .in_address(in_address), .in_last(in_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .done(done), .full(full), .word_count(word_count)
  );

  instr_encode_loader #(.MEM_DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(d4_in_ready),
    .in_iden(in_iden), .in_opcode(in_opcode), .in_address(in_address), .in_last(in_last),
    .mem_we(d4_mem_we), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata), .mem_ack(mem_ack),
    .done(d4_done), .full(d4_full), .word_count(d4_word_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Outputs are sampled 1ns after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Present one field triple for exactly one edge (caller ensures in_ready=1).
  task automatic send(input logic [1:0] iden, input logic [3:0] op,
                      input logic [7:0] addr, input logic last);
    in_iden    = iden;
    in_opcode  = op;
    in_address = addr;
    in_last    = last;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
  endtask

  logic [15:0] burst_word [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    burst_word[0] = 16'h0110;
    burst_word[1] = 16'h1211;
    burst_word[2] = 16'h2312;
    burst_word[3] = 16'h3413;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_iden = '0;
    in_opcode = '0; in_address = '0; in_last = 1'b0; mem_ack = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_we",    32'(mem_we),     32'd0);
    check("rst_addr",  32'(mem_addr),   32'h00);
    check("rst_wdata", 32'(mem_wdata),  32'h0);
    check("rst_done",  32'(done),       32'd0);
    check("rst_full",  32'(full),       32'd0);
    check("rst_count", 32'(word_count), 32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_ready", 32'(in_ready), 32'd1);

    // 1. Single word with LAST
    mem_ack = 1'b1;
    send(2'b01, 4'hA, 8'h3C, 1'b1);
    check("t1_we",    32'(mem_we),    32'd1);
    check("t1_addr",  32'(mem_addr),  32'h00);
    check("t1_wdata", 32'(mem_wdata), 32'h1A3C);
    check("t1_ready", 32'(in_ready),  32'd0);
    tick();
    check("t1_done",  32'(done),       32'd1);
    check("t1_count", 32'(word_count), 32'd1);
    check("t1_we_lo", 32'(mem_we),     32'd0);

    // 2. Burst of 4, ack tied high: one write every 2 cycles
    do_reset();
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_ready", 32'(in_ready), 32'd1);
      send(2'(i), 4'(i + 1), 8'(8'h10 + i), i == 3);
      check("t2_we",    32'(mem_we),    32'd1);
      check("t2_addr",  32'(mem_addr),  32'(i));
      check("t2_wdata", 32'(mem_wdata), 32'(burst_word[i]));
      tick();
      check("t2_we_lo", 32'(mem_we),     32'd0);
      check("t2_count", 32'(word_count), 32'(i + 1));
    end
    check("t2_done", 32'(done), 32'd1);
    check("t2_full", 32'(full), 32'd0);

    // 3. Stalled memory: ack low for 3 edges, then high
    do_reset();
    mem_ack = 1'b0;
    send(2'b10, 4'h5, 8'h77, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("t3_we",    32'(mem_we),     32'd1);
      check("t3_addr",  32'(mem_addr),   32'h00);
      check("t3_wdata", 32'(mem_wdata),  32'h2577);
      check("t3_ready", 32'(in_ready),   32'd0);
      check("t3_count", 32'(word_count), 32'd0);
      if (k == 3) mem_ack = 1'b1;
      tick();
    end
    check("t3_we_lo", 32'(mem_we),     32'd0);
    check("t3_count", 32'(word_count), 32'd1);
    check("t3_ready", 32'(in_ready),   32'd1);
    check("t3_done",  32'(done),       32'd0);
    tick();
    check("t3_count_once", 32'(word_count), 32'd1);

    // 4. Full on the MEM_DEPTH=4 instance, 6 words offered with no LAST
    do_reset();
    mem_ack = 1'b1;
    for (int w = 0; w < 4; w++) begin
      check("t4_ready", 32'(d4_in_ready), 32'd1);
      check("t4_full_pre", 32'(d4_full), 32'd0);
      send(2'b00, 4'h1, 8'(w), 1'b0);
      check("t4_we",   32'(d4_mem_we),   32'd1);
      check("t4_addr", 32'(d4_mem_addr), 32'(w));
      tick();
    end
    check("t4_full",  32'(d4_full),       32'd1);
    check("t4_done",  32'(d4_done),       32'd1);
    check("t4_count", 32'(d4_word_count), 32'd4);
    in_iden = 2'b11; in_opcode = 4'h2; in_address = 8'h55; in_last = 1'b0;
    in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("t4_ready_lo", 32'(d4_in_ready),   32'd0);
      check("t4_no_we",    32'(d4_mem_we),     32'd0);
      check("t4_hold_cnt", 32'(d4_word_count), 32'd4);
      tick();
    end
    in_valid = 1'b0;
    check("t4_addr_hold", 32'(d4_mem_addr), 32'h03);

    // 5. Reset during a stalled write at a non-start address
    do_reset();
    mem_ack = 1'b1;
    send(2'b01, 4'h1, 8'h01, 1'b0);
    tick();
    mem_ack = 1'b0;
    send(2'b01, 4'h2, 8'h02, 1'b0);
    check("t5_we",   32'(mem_we),     32'd1);
    check("t5_addr", 32'(mem_addr),   32'h01);
    check("t5_cnt",  32'(word_count), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t5_we_rst",   32'(mem_we),     32'd0);
    check("t5_cnt_rst",  32'(word_count), 32'd0);
    check("t5_addr_rst", 32'(mem_addr),   32'h00);
    rst_n = 1'b1;
    tick();
    check("t5_ready", 32'(in_ready), 32'd1);
    check("t5_we_lo", 32'(mem_we),   32'd0);

    // 6. CLEAR during WRITE is ignored; CLEAR from DONE restarts the load
    do_reset();
    mem_ack = 1'b1;
    send(2'b00, 4'h3, 8'h10, 1'b0);
    tick();
    mem_ack = 1'b0;
    send(2'b00, 4'h4, 8'h20, 1'b1);
    clear = 1'b1;
    tick();
    check("t6_clr_we",   32'(mem_we),   32'd1);
    check("t6_clr_addr", 32'(mem_addr), 32'h01);
    mem_ack = 1'b1;
    tick();
    clear = 1'b0;
    check("t6_done",  32'(done),       32'd1);
    check("t6_count", 32'(word_count), 32'd2);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("t6_done_clr",  32'(done),       32'd0);
    check("t6_full_clr",  32'(full),       32'd0);
    check("t6_count_clr", 32'(word_count), 32'd0);
    check("t6_ready",     32'(in_ready),   32'd1);
    send(2'b11, 4'hF, 8'hFF, 1'b1);
    check("t6_we",    32'(mem_we),    32'd1);
    check("t6_addr",  32'(mem_addr),  32'h00);
    check("t6_wdata", 32'(mem_wdata), 32'h3FFF);
    tick();
    check("t6_done2",  32'(done),       32'd1);
    check("t6_count2", 32'(word_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
